// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared encodings for the UART TX write-port arbiter
package uart_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

    localparam logic OWN0 = 1'b0;
    localparam logic OWN1 = 1'b1;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT0     = 2'b01;
    localparam logic [1:0] GNT1     = 2'b10;

    function automatic logic [1:0] owner_grant(input logic owner);
        return (owner == OWN1) ? GNT1 : GNT0;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin pick; the side that did not win last goes first
module rr_pick2
    import uart_arb_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic last_owner,
    output logic any_valid,
    output logic winner
);

    always_comb begin
        any_valid = valid0 | valid1;
        winner    = OWN0;
        if (valid0 && valid1) begin
            winner = ~last_owner;
        end else if (valid1) begin
            winner = OWN1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-locked round-robin share of the UART TX FIFO write port
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req0_last,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              req1_last,
    output logic              req1_ready,
    input  logic              tx_full,
    output logic              wr_uart,
    output logic [DATA_W-1:0] w_data,
    output logic [1:0]        grant,
    output logic              abort
);

    arb_state_t        state;
    logic              owner;
    logic              last_owner;
    logic [CNT_W-1:0]  idle_cnt;

    logic              pick_any;
    logic              pick_winner;
    logic              owner_valid;
    logic              owner_last;
    logic [DATA_W-1:0] owner_data;
    logic              xfer;
    logic              timeout_hit;

    rr_pick2 u_pick (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_owner (last_owner),
        .any_valid  (pick_any),
        .winner     (pick_winner)
    );

    // Reset gates the strobe so nothing reaches the FIFO while the lock is being dropped.
    always_comb begin
        owner_valid = (owner == OWN1) ? req1_valid : req0_valid;
        owner_last  = (owner == OWN1) ? req1_last  : req0_last;
        owner_data  = (owner == OWN1) ? req1_data  : req0_data;
        xfer        = (state == ST_LOCK) && owner_valid && !tx_full && !reset;
        timeout_hit = (state == ST_LOCK) && !owner_valid
                      && (idle_cnt == CNT_W'(TIMEOUT - 1));
    end

    assign wr_uart    = xfer;
    assign req0_ready = xfer && (owner == OWN0);
    assign req1_ready = xfer && (owner == OWN1);
    assign w_data     = xfer ? owner_data : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            owner      <= OWN0;
            last_owner <= OWN1;
            idle_cnt   <= '0;
            grant      <= GNT_NONE;
            abort      <= 1'b0;
        end else begin
            abort <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        state    <= ST_LOCK;
                        owner    <= pick_winner;
                        grant    <= owner_grant(pick_winner);
                        idle_cnt <= '0;
                    end
                end
                ST_LOCK: begin
                    if (xfer) begin
                        idle_cnt <= '0;
                        if (owner_last) begin
                            state      <= ST_IDLE;
                            last_owner <= owner;
                            grant      <= GNT_NONE;
                        end
                    end else if (!owner_valid) begin
                        // Only an absent owner ages the lock; FIFO back-pressure never does.
                        if (timeout_hit) begin
                            state      <= ST_IDLE;
                            last_owner <= owner;
                            grant      <= GNT_NONE;
                            idle_cnt   <= '0;
                            abort      <= 1'b1;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
